uart_rx: RTL and testbench

- UART receiver; the counterpart of the existing UART transmit path.
- Recovers 8-bit frames from the serial line: 1 start bit (0), 8 data bits LSB first, optional parity bit, 1 stop bit (1).
- Oversamples the line on an externally supplied baud_tick (OVERSAMPLE ticks per bit) and samples at mid-bit.
- Presents each received byte with a one-cycle rx_valid pulse and per-frame error flags.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/rx_shift_reg.sv | 33 +++
 rtl/uart_rx.sv | 182 ++++++++++++++++++
 tb/tb_uart_rx.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg : shared UART types, widths and parity helper.  rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int IDX_W     = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_t;

  // Parity bit a transmitter appends so the total count of ones matches 'odd'.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rx_shift_reg.sv
// ---------------------------------------------------------------------------
// rx_shift_reg : data byte with per-bit indexed load and XOR reduction.  rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rx_shift_reg
  import uart_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic [IDX_W-1:0]     idx_i,
  input  logic                 bit_i,
  output logic [DATA_BITS-1:0] byte_o,
  output logic                 xor_o
);

  logic [DATA_BITS-1:0] data_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q[idx_i] <= bit_i;
    end
  end

  assign byte_o = data_q;
  assign xor_o  = ^data_q;

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx : oversampling UART receiver, 8N1 / 8E1 / 8O1 with error flags.  rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx_serial,
  input  logic                 baud_tick,
  input  logic                 parity_enable,
  input  logic                 parity_odd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 rx_busy
);

  localparam int               CNT_W     = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] c_mid_cnt = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] c_bit_cnt = CNT_W'(OVERSAMPLE - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   w_rxs;

  rx_state_t              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   par_en_q, par_en_d;
  logic                   par_odd_q, par_odd_d;
  logic                   frame_perr_q, frame_perr_d;
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   valid_q, valid_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;

  logic                   w_shift_load;
  logic [DATA_BITS-1:0]   w_shift_byte;
  logic                   w_shift_xor;

  assign w_rxs = sync_q[SYNC_STAGES-1];

  rx_shift_reg u_shift (
    .clock  (clock),
    .reset  (reset),
    .load_i (w_shift_load),
    .idx_i  (idx_q),
    .bit_i  (w_rxs),
    .byte_o (w_shift_byte),
    .xor_o  (w_shift_xor)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q       <= '1;
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      par_en_q     <= 1'b0;
      par_odd_q    <= 1'b0;
      frame_perr_q <= 1'b0;
      rx_data_q    <= '0;
      valid_q      <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], rx_serial};
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      par_en_q     <= par_en_d;
      par_odd_q    <= par_odd_d;
      frame_perr_q <= frame_perr_d;
      rx_data_q    <= rx_data_d;
      valid_q      <= valid_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    par_en_d     = par_en_q;
    par_odd_d    = par_odd_q;
    frame_perr_d = frame_perr_q;
    rx_data_d    = rx_data_q;
    valid_d      = 1'b0;
    perr_d       = perr_q;
    ferr_d       = ferr_q;
    w_shift_load = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (baud_tick && !w_rxs) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (baud_tick) begin
          if (cnt_q == c_mid_cnt) begin
            cnt_d = '0;
            if (w_rxs) begin
              state_d = IDLE;
            end else begin
              state_d      = DATA;
              idx_d        = '0;
              par_en_d     = parity_enable;
              par_odd_d    = parity_odd;
              frame_perr_d = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (cnt_q == c_bit_cnt) begin
            w_shift_load = 1'b1;
            cnt_d        = '0;
            idx_d        = idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(DATA_BITS - 1)) begin
              state_d = par_en_q ? PARITY : STOP;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      PARITY: begin
        if (baud_tick) begin
          if (cnt_q == c_bit_cnt) begin
            frame_perr_d = (w_rxs != parity_bit(w_shift_byte, par_odd_q));
            cnt_d        = '0;
            state_d      = STOP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      STOP: begin
        if (baud_tick) begin
          if (cnt_q == c_bit_cnt) begin
            valid_d   = 1'b1;
            rx_data_d = w_shift_byte;
            perr_d    = par_en_q & frame_perr_q;
            ferr_d    = ~w_rxs;
            cnt_d     = '0;
            state_d   = w_rxs ? IDLE : BREAK;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      BREAK: begin
        // Line held low past the stop bit: wait for it to idle before hunting.
        if (w_rxs) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = valid_q;
  assign parity_error  = perr_q;
  assign framing_error = ferr_q;
  assign rx_busy       = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx : frame-level reference model and per-cycle compare for uart_rx.  rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx;

  localparam int OS       = 16;
  localparam int TICK_DIV = 4;
  localparam int BIT_CLKS = OS * TICK_DIV;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rx_serial = 1'b1;
  logic       baud_tick = 1'b0;
  logic       parity_enable = 1'b0;
  logic       parity_odd = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_error;
  logic       framing_error;
  logic       rx_busy;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_valid  = 0;
  logic [7:0] hold_d   = 8'h00;
  logic       hold_pe  = 1'b0;
  logic       hold_fe  = 1'b0;
  logic       stop_win = 1'b0;

  uart_rx #(.OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
    .clock         (clock),
    .reset         (reset),
    .rx_serial     (rx_serial),
    .baud_tick     (baud_tick),
    .parity_enable (parity_enable),
    .parity_odd    (parity_odd),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .parity_error  (parity_error),
    .framing_error (framing_error),
    .rx_busy       (rx_busy)
  );

  always #5 clock = ~clock;

  initial begin
    forever begin
      repeat (TICK_DIV - 1) @(posedge clock);
      #1 baud_tick = 1'b1;
      @(posedge clock);
      #1 baud_tick = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  // Outputs must always equal the last completed frame's expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset) begin
        hold_d  = 8'h00;
        hold_pe = 1'b0;
        hold_fe = 1'b0;
      end else begin
        if (rx_valid) begin
          n_valid++;
          check("valid_in_stop_window", 32'(stop_win), 32'd1);
          if (exp_q.size() == 0) begin
            check("unexpected_rx_valid", 32'd1, 32'd0);
          end else begin
            e       = exp_q.pop_front();
            hold_d  = e.d;
            hold_pe = e.pe;
            hold_fe = e.fe;
          end
        end
        check("rx_data", 32'(rx_data), 32'(hold_d));
        check("parity_error", 32'(parity_error), 32'(hold_pe));
        check("framing_error", 32'(framing_error), 32'(hold_fe));
      end
    end
  end

  task automatic drive_bit(input logic b);
    rx_serial = b;
    repeat (BIT_CLKS) @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    rx_serial = 1'b1;
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Sends one frame; 'flip' corrupts the parity bit, 'stop' is the stop level.
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic podd,
                            input logic flip, input logic stop, input bit expect_it);
    exp_t e;
    logic good_par;
    good_par = ((($countones(d) + int'(podd)) % 2) == 1);
    e.d  = d;
    e.pe = pen & flip;
    e.fe = ~stop;
    if (expect_it) exp_q.push_back(e);
    @(posedge clock);
    #1;
    parity_enable = pen;
    parity_odd    = podd;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 1) begin
        parity_enable = 1'($urandom);
        parity_odd    = 1'($urandom);
      end
      drive_bit(d[i]);
    end
    if (pen) drive_bit(good_par ^ flip);
    rx_serial = stop;
    repeat (20) @(posedge clock);
    stop_win = 1'b1;
    repeat (30) @(posedge clock);
    stop_win = 1'b0;
    repeat (BIT_CLKS - 50) @(posedge clock);
    #1;
  endtask

  initial begin
    int base;
    logic [7:0] rd;
    logic rpen, rpodd, rflip, rstop;

    repeat (5) @(posedge clock);
    @(negedge clock);
    check("reset_rx_data", 32'(rx_data), 32'h00);
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_rx_busy", 32'(rx_busy), 32'd0);
    check("reset_errors", 32'({parity_error, framing_error}), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    idle(100);

    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clock);
    check("basic_data", 32'(rx_data), 32'hA5);
    check("basic_errors", 32'({parity_error, framing_error}), 32'd0);
    check("basic_count", 32'(n_valid), 32'd1);

    idle(30);
    send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clock);
    check("even_par_ok", 32'(parity_error), 32'd0);
    idle(17);
    send_frame(8'h07, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    @(negedge clock);
    check("even_par_bad", 32'(parity_error), 32'd1);
    check("even_par_bad_data", 32'(rx_data), 32'h07);

    idle(25);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    rx_serial = 1'b0;
    repeat (3 * BIT_CLKS) @(posedge clock);
    @(negedge clock);
    check("break_ferr", 32'(framing_error), 32'd1);
    check("break_data", 32'(rx_data), 32'h3C);
    check("break_busy", 32'(rx_busy), 32'd1);
    @(posedge clock);
    #1;
    idle(12);
    @(negedge clock);
    check("break_released", 32'(rx_busy), 32'd0);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clock);
    check("after_break_data", 32'(rx_data), 32'h55);
    check("after_break_ferr", 32'(framing_error), 32'd0);

    idle(40);
    base = n_valid;
    rx_serial = 1'b0;
    repeat (3 * TICK_DIV - 1) @(posedge clock);
    @(negedge clock);
    check("glitch_busy", 32'(rx_busy), 32'd1);
    @(posedge clock);
    #1;
    idle(200);
    @(negedge clock);
    check("glitch_idle", 32'(rx_busy), 32'd0);
    check("glitch_no_valid", 32'(n_valid), 32'(base));

    @(posedge clock);
    #1;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    repeat (30) @(posedge clock);
    @(negedge clock);
    check("midframe_busy", 32'(rx_busy), 32'd1);
    @(posedge clock);
    #1 reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    idle(150);
    @(negedge clock);
    check("midreset_data", 32'(rx_data), 32'h00);
    check("midreset_busy", 32'(rx_busy), 32'd0);
    check("midreset_no_valid", 32'(n_valid), 32'(base));
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clock);
    check("after_reset_data", 32'(rx_data), 32'h81);

    base = n_valid;
    send_frame(8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    @(negedge clock);
    check("b2b_count", 32'(n_valid), 32'(base + 3));
    check("b2b_last_data", 32'(rx_data), 32'h5A);
    check("b2b_parity", 32'(parity_error), 32'd0);

    for (int k = 0; k < 25; k++) begin
      rd    = 8'($urandom);
      rpen  = 1'($urandom);
      rpodd = 1'($urandom);
      rflip = ($urandom_range(0, 3) == 0);
      rstop = ($urandom_range(0, 5) != 0);
      send_frame(rd, rpen, rpodd, rflip, rstop, 1'b1);
      if (!rstop) begin
        repeat ($urandom_range(0, 2 * BIT_CLKS)) @(posedge clock);
        #1;
        idle(8 + $urandom_range(0, 40));
      end else begin
        idle($urandom_range(0, 120));
      end
    end

    for (int t = 0; t < 500 && exp_q.size() != 0; t++) @(posedge clock);
    @(negedge clock);
    check("all_frames_received", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
